booth_mult_seq: RTL and testbench
=================================

# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier: next generation of the FPU mantissa multiplier, with configurable operand width, per-request signed/unsigned mode, done/busy/error status and an asynchronous reset. Partial-product add/subtract is delegated to a shared external adder through a valid/ack handshake, so the block holds only shift/count state. It sits between the FPU multiply datapath (mantissa product, W=24) and the shared adder.

## Interface
- W, 24: operand width in bits (≥4); adder path is W+1 bits, product 2W bits.
- CNT_W, $clog2(W+2): iteration counter width.

- CLK  in  1  clock, all state on rising edge.
- RSTK  in  1  reset, asynchronous, active-low.
- req  in  1  start request, sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with req.
- m1  in  W  multiplicand, captured with req.
- m2  in  W  multiplier, captured with req.
- res  out  2W  product; valid from done onward, held until next accepted req.
- done  out  1  one-cycle pulse, product ready.
- busy  out  1  high from accepted req until done cycle inclusive.
- err  out  1  sticky per operation: any Adder_Exc≠0 seen with Adder_ack; cleared on next accepted req.
- Adder_valid  out  1  adder request, registered.
- Adder_datain1  out  W+1  accumulator A.
- Adder_datain2  out  W+1  M or (~M+1).
- Adder_dataout  in  W+1  sum.
- Adder_carryout  in  1  ignored (modulo 2^(W+1)).
- Adder_Exc  in  2  adder exception code.
- Adder_ack  in  1  one-cycle result strobe.

## Operation
- Operand extension to W+1 bits: signed_mode=1 sign-extends, 0 zero-extends; M=ext(m1), Q=ext(m2), A=0, Q1=0, count=0.
- States: IDLE, SCAN, ADD_WAIT, DONE.
- IDLE: req=1 -> load registers, clear err, busy=1, go SCAN. req=0 -> stay.
- SCAN, pair {Q[0],Q1}: 00/11 -> arithmetic right shift {A,Q,Q1} by one, count+1; 01 -> Adder_valid=1, datain1=A, datain2=M, go ADD_WAIT; 10 -> same with datain2=~M+1.
- ADD_WAIT: hold Adder_valid and data stable until Adder_ack=1; on ack capture {Adder_dataout[W],Adder_dataout,Q} as new {A,Q,Q1} (shift fused with add), drop Adder_valid, count+1, OR Exc≠0 into err, return to SCAN.
- After count reaches W+1 (from either state) go DONE; res = {A,Q}[2W-1:0].
- DONE: done=1 for one cycle, busy deasserts next cycle, go IDLE.
- req outside IDLE ignored, no queueing. Adder_ack outside ADD_WAIT ignored.

## Timing
- Reset values: res=0, done=0, busy=0, err=0, Adder_valid=0, Adder_datain1=0, Adder_datain2=0; state IDLE. Reset mid-operation aborts immediately, Adder_valid drops asynchronously.
- req sampled at edge k -> SCAN from k+1; with no adds done is high in cycle k+W+2.
- Each add iteration costs 1 issue cycle + L cycles until ack (L≥1, ack earliest the cycle after Adder_valid rises); total latency = W+2 + Σ L over add iterations.
- Adder_valid falls on the edge that samples Adder_ack; never high two cycles after ack.
- req and done in same cycle: req ignored (state is DONE); accepted next cycle in IDLE.

## Structure
- Shared FPU package: typedef enum BoothSeqState {IDLE, SCAN, ADD_WAIT, DONE}; adder exception code constants.
- No sub-module required; optional booth_pair_decode (2-bit pair -> {nop, add, sub}) may be split out.
- Single registered-state process plus combinational next-state process.

## Test plan
- W=8 unsigned 255×255 -> res=0xFE01, err=0, done once.
- W=8 signed -128×-128 -> res=0x4000; signed -1×1 -> res=0xFFFF; unsigned 0xFF×1 -> 0x00FF.
- m2=0, any m1 -> res=0, Adder_valid never asserted, done exactly W+2 cycles after req.
- Adder ack latency randomised 1..5 over 200 random operands, both modes -> res matches reference product; Adder_valid/data stable while waiting.
- Adder_Exc=2'b01 on one ack -> err=1 at done; next req clears err.
- RSTK low during ADD_WAIT -> all outputs zero immediately; new req after release gives correct product.

Source files
------------

// File: rtl/booth_mult_seq_pkg.sv
// Shared FPU definitions for the sequential Booth multiplier: controller states,
// Booth pair operations and the exception codes reported by the shared adder.
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    ADD_WAIT = 2'd2,
    DONE     = 2'd3
  } booth_seq_state_e;

  typedef enum logic [1:0] {
    PAIR_NOP = 2'd0,
    PAIR_ADD = 2'd1,
    PAIR_SUB = 2'd2
  } booth_op_e;

  localparam logic [1:0] ADDER_EXC_NONE = 2'b00;
  localparam logic [1:0] ADDER_EXC_OVF  = 2'b01;
  localparam logic [1:0] ADDER_EXC_UNF  = 2'b10;
  localparam logic [1:0] ADDER_EXC_INV  = 2'b11;

endpackage

// File: rtl/booth_mult_seq_pair_decode.sv
// Radix-2 Booth recoding of the {Q[0],Q1} bit pair into nop / add M / subtract M.
module booth_pair_decode
  import booth_mult_seq_pkg::*;
(
  input  logic      q0,
  input  logic      q1,
  output booth_op_e op
);

  always_comb begin
    op = PAIR_NOP;
    case ({q0, q1})
      2'b01:   op = PAIR_ADD;
      2'b10:   op = PAIR_SUB;
      default: op = PAIR_NOP;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier; partial-product add/subtract is performed by
// a shared external adder, so this block only keeps the shift/count state.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int W     = 24,
  parameter int CNT_W = $clog2(W + 2)
) (
  input  logic             CLK,
  input  logic             RSTK,
  input  logic             req,
  input  logic             signed_mode,
  input  logic [W-1:0]     m1,
  input  logic [W-1:0]     m2,
  output logic [2*W-1:0]   res,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic             Adder_valid,
  output logic [W:0]       Adder_datain1,
  output logic [W:0]       Adder_datain2,
  input  logic [W:0]       Adder_dataout,
  input  logic             Adder_carryout,
  input  logic [1:0]       Adder_Exc,
  input  logic             Adder_ack,
  output booth_seq_state_e dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W + 1);

  booth_seq_state_e state_q, state_d;
  logic [W:0]       a_q, a_d;
  logic [W:0]       q_q, q_d;
  logic             q1_q, q1_d;
  logic [W:0]       m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [W:0]       din1_q, din1_d;
  logic [W:0]       din2_q, din2_d;

  booth_op_e        pair_op;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_carry;

  // The adder result wraps modulo 2^(W+1); its carry-out carries no information here.
  assign unused_carry = Adder_carryout;

  booth_pair_decode u_pair_decode (
    .q0 (q_q[0]),
    .q1 (q1_q),
    .op (pair_op)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Adder handshake: Adder_valid and both data words are held constant from the
  // issue edge until the edge that samples Adder_ack; that same edge drops
  // Adder_valid. Adder_ack is only looked at while waiting in ADD_WAIT.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    valid_d = valid_q;
    din1_d  = din1_q;
    din2_d  = din2_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          m_d     = signed_mode ? {m1[W-1], m1} : {1'b0, m1};
          q_d     = signed_mode ? {m2[W-1], m2} : {1'b0, m2};
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        case (pair_op)
          PAIR_ADD: begin
            valid_d = 1'b1;
            din1_d  = a_q;
            din2_d  = m_q;
            state_d = ADD_WAIT;
          end
          PAIR_SUB: begin
            valid_d = 1'b1;
            din1_d  = a_q;
            din2_d  = ~m_q + (W+1)'(1);
            state_d = ADD_WAIT;
          end
          default: begin
            a_d     = {a_q[W], a_q[W:1]};
            q_d     = {a_q[0], q_q[W:1]};
            q1_d    = q_q[0];
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == LAST_CNT) ? DONE : SCAN;
          end
        endcase
      end

      ADD_WAIT: begin
        if (Adder_ack) begin
          // The sum is written back already shifted, so an add iteration needs no
          // separate shift cycle.
          a_d     = {Adder_dataout[W], Adder_dataout[W:1]};
          q_d     = {Adder_dataout[0], q_q[W:1]};
          q1_d    = q_q[0];
          cnt_d   = cnt_inc;
          valid_d = 1'b0;
          err_d   = err_q | (Adder_Exc != ADDER_EXC_NONE);
          state_d = (cnt_inc == LAST_CNT) ? DONE : SCAN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == DONE) && (state_q != DONE)) begin
      res_d = {a_d[W-2:0], q_d};
    end
  end

  always_ff @(posedge CLK or negedge RSTK) begin
    if (!RSTK) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      din1_q  <= '0;
      din2_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
    end
  end

  assign res           = res_q;
  assign done          = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign Adder_valid   = valid_q;
  assign Adder_datain1 = din1_q;
  assign Adder_datain2 = din2_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at W=8: random operands against an integer product model,
// with a randomly slow external adder model.
module tb_booth_mult_seq;
  import booth_mult_seq_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W + 2);

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic RSTK = 1'b0;
  always #5 CLK = ~CLK;

  logic             req = 1'b0;
  logic             signed_mode = 1'b0;
  logic [W-1:0]     m1 = '0;
  logic [W-1:0]     m2 = '0;
  logic [2*W-1:0]   res;
  logic             done;
  logic             busy;
  logic             err;
  logic             Adder_valid;
  logic [W:0]       Adder_datain1;
  logic [W:0]       Adder_datain2;
  logic [W:0]       Adder_dataout = '0;
  logic             Adder_carryout = 1'b0;
  logic [1:0]       Adder_Exc = 2'b00;
  logic             Adder_ack = 1'b0;
  booth_seq_state_e dbg_state;

  booth_mult_seq #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .RSTK           (RSTK),
    .req            (req),
    .signed_mode    (signed_mode),
    .m1             (m1),
    .m2             (m2),
    .res            (res),
    .done           (done),
    .busy           (busy),
    .err            (err),
    .Adder_valid    (Adder_valid),
    .Adder_datain1  (Adder_datain1),
    .Adder_datain2  (Adder_datain2),
    .Adder_dataout  (Adder_dataout),
    .Adder_carryout (Adder_carryout),
    .Adder_Exc      (Adder_Exc),
    .Adder_ack      (Adder_ack),
    .dbg_state      (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sum_l    = 0;
  int n_done   = 0;
  bit exc_once = 1'b0;
  bit valid_seen = 1'b0;

  // scoreboard: {err, res} plus the request cycle and adder-latency sum at issue
  logic [2*W:0] exp_q[$];
  int           t_q[$];
  int           l_q[$];

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input bit s, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint x;
    longint y;
    longint p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*W-1:0];
  endfunction

  // ---------------- external adder model ----------------
  initial begin
    int lat_left;
    bit real_ack;
    bit was_real;
    logic [W:0] hold1;
    logic [W:0] hold2;
    lat_left = 0;
    real_ack = 1'b0;
    hold1 = '0;
    hold2 = '0;
    forever begin
      @(posedge CLK);
      #1;
      was_real  = real_ack;
      real_ack  = 1'b0;
      Adder_ack = 1'b0;
      Adder_Exc = ADDER_EXC_NONE;
      Adder_carryout = 1'($urandom_range(0, 1));
      if (was_real && RSTK) check("valid_drop_after_ack", Adder_valid, 1'b0);
      if (!Adder_valid) begin
        lat_left = 0;
        if (RSTK && $urandom_range(0, 7) == 0) begin
          Adder_ack     = 1'b1;
          Adder_dataout = (W+1)'($urandom);
          Adder_Exc     = ADDER_EXC_INV;
        end
      end else begin
        if (lat_left == 0) begin
          lat_left = $urandom_range(1, 5);
          sum_l   += lat_left;
          hold1    = Adder_datain1;
          hold2    = Adder_datain2;
        end else begin
          check("datain1_stable", Adder_datain1, hold1);
          check("datain2_stable", Adder_datain2, hold2);
        end
        lat_left--;
        if (lat_left == 0) begin
          Adder_ack     = 1'b1;
          Adder_dataout = hold1 + hold2;
          Adder_Exc     = exc_once ? ADDER_EXC_OVF : ADDER_EXC_NONE;
          exc_once      = 1'b0;
          real_ack      = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (Adder_valid) valid_seen = 1'b1;
    if (RSTK && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done with empty scoreboard (cycle %0d)", cyc);
      end else begin
        logic [2*W:0] e;
        int tr;
        int sl;
        e  = exp_q.pop_front();
        tr = t_q.pop_front();
        sl = l_q.pop_front();
        check("res", res, e[2*W-1:0]);
        check("err", err, e[2*W]);
        check("busy_at_done", busy, 1'b1);
        check("latency", cyc + 1 - tr, W + 2 + (sum_l - sl));
        n_done++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < 1000) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: busy still high after 1000 cycles", name);
    end
  endtask

  task automatic do_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit inj, input int hold);
    wait_idle("wait_before_req");
    exc_once    = inj;
    req         = 1'b1;
    signed_mode = s;
    m1          = a;
    m2          = b;
    exp_q.push_back({inj, ref_prod(s, a, b)});
    t_q.push_back(cyc + 1);
    l_q.push_back(sum_l);
    @(posedge CLK);
    #1;
    for (int i = 0; i < hold; i++) begin
      m1          = W'($urandom);
      m2          = W'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      @(posedge CLK);
      #1;
    end
    req = 1'b0;
    m1  = W'($urandom);
    m2  = W'($urandom);
    wait_idle("wait_for_done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int done_before;

    RSTK = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_res", res, '0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_valid", Adder_valid, 1'b0);
    check("rst_din1", Adder_datain1, '0);
    check("rst_din2", Adder_datain2, '0);
    check("rst_state", dbg_state, IDLE);
    @(negedge CLK);
    RSTK = 1'b1;
    @(posedge CLK);
    #1;

    do_op(1'b0, 8'hFF, 8'hFF, 1'b0, 0);
    do_op(1'b1, 8'h80, 8'h80, 1'b0, 0);
    do_op(1'b1, 8'hFF, 8'h01, 1'b0, 0);
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, 0);
    do_op(1'b1, 8'h7F, 8'h80, 1'b0, 2);

    valid_seen  = 1'b0;
    done_before = n_done;
    do_op(1'b1, W'($urandom), 8'h00, 1'b0, 0);
    check("no_adder_for_zero", valid_seen, 1'b0);
    check("zero_done_once", n_done - done_before, 1);

    do_op(1'b0, 8'hFF, 8'hFF, 1'b1, 0);
    do_op(1'b0, 8'h03, 8'h05, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      do_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0, 0);
    end

    // abort while the adder is pending
    wait_idle("wait_before_abort");
    req = 1'b1;
    signed_mode = 1'b0;
    m1 = 8'h55;
    m2 = 8'h01;
    @(posedge CLK);
    #1;
    req = 1'b0;
    guard = 0;
    while (!Adder_valid && guard < 50) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    check("abort_valid_reached", Adder_valid, 1'b1);
    #2;
    RSTK = 1'b0;
    #1;
    check("abort_res", res, '0);
    check("abort_done", done, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_err", err, 1'b0);
    check("abort_valid", Adder_valid, 1'b0);
    check("abort_din1", Adder_datain1, '0);
    check("abort_din2", Adder_datain2, '0);
    exc_once = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RSTK = 1'b1;
    @(posedge CLK);
    #1;
    do_op(1'b1, 8'h9C, 8'h37, 1'b0, 0);
    do_op(1'b0, 8'hC8, 8'hAB, 1'b0, 0);

    wait_idle("final_idle");
    repeat (2) @(posedge CLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
